// File: rtl/usb_output_if.sv
// usb_output_if: byte-stream and FTDI FT245 write-side signals of usb_output.
//   master : producer/board side (drives in, newin, txe; observes the rest)
//   slave  : usb_output itself
// Signals:
//   in, newin        byte to transmit and its one-cycle push strobe
//   full, count      FIFO status (count is DEPTH_LOG2+1 bits wide)
//   overflow         sticky push-while-full flag
//   data_out/data_oe FTDI data bus value and its output enable
//   txe              FTDI TXE# (active low, asynchronous)
//   wr               FTDI WR strobe
//   bytes_sent       completed transfers, modulo 2^16
//   state            FSM state for debug
interface usb_output_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic [7:0]          in;
  logic                newin;
  logic                txe;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic [7:0]          data_out;
  logic                data_oe;
  logic                wr;
  logic [15:0]         bytes_sent;
  logic [3:0]          state;

  modport master (
    output in, newin, txe,
    input  full, count, overflow, data_out, data_oe, wr, bytes_sent, state
  );

  modport slave (
    input  in, newin, txe,
    output full, count, overflow, data_out, data_oe, wr, bytes_sent, state
  );
endinterface

// File: rtl/usb_output.sv
// usb_output: transmit path to the host through an FTDI FT245-style FIFO.
// Bytes pushed with a one-cycle newin strobe are buffered in an internal
// FIFO of 2^DEPTH_LOG2 entries and written out one at a time with the
// SETUP / STROBE / HOLD / WAIT handshake, paced by the synchronised TXE#.
// Ports:
//   clock    system clock
//   reset_b  asynchronous active-low reset
//   port     usb_output_if.slave (byte input, FIFO status, FTDI pins, debug)
// Parameters:
//   DEPTH_LOG2  log2 of FIFO depth
//   WR_PULSE    cycles WR is held high (>= 1)
//   GAP         idle cycles after each byte before TXE# is trusted (>= 3)
module usb_output #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WR_PULSE   = 2,
  parameter int GAP        = 4
) (
  input  logic        clock,
  input  logic        reset_b,
  usb_output_if.slave port
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    SETUP  = 4'd1,
    STROBE = 4'd2,
    HOLD   = 4'd3,
    WAIT   = 4'd4
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         cycCnt_q, cycCnt_d;
  logic                  settle_q;
  logic                  txeMeta_q, txeSync_q;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, overflow_q;
  logic                  wr_q, dataOe_q;
  logic [7:0]            dataOut_q;
  logic [15:0]           bytesSent_q;
  logic                  push, pop;

  // Pushes are gated by the registered full flag, so a push that meets a
  // pop while full is still dropped.
  assign push    = port.newin && !full_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Next-state logic. The pop happens on the IDLE->SETUP transition.
  // settle_q keeps IDLE for one cycle after WAIT, so consecutive bytes are
  // 4+WR_PULSE+GAP cycles apart.
  always_comb begin
    state_d  = state_q;
    cycCnt_d = cycCnt_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!settle_q && (count_q != '0) && !txeSync_q) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d  = STROBE;
        cycCnt_d = '0;
      end
      STROBE: begin
        if (cycCnt_q == TW'(WR_PULSE - 1)) begin
          state_d  = HOLD;
          cycCnt_d = '0;
        end else begin
          cycCnt_d = cycCnt_q + TW'(1);
        end
      end
      HOLD: begin
        state_d  = WAIT;
        cycCnt_d = '0;
      end
      WAIT: begin
        if (cycCnt_q == TW'(GAP - 1)) begin
          state_d  = IDLE;
          cycCnt_d = '0;
        end else begin
          cycCnt_d = cycCnt_q + TW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cycCnt_d = '0;
      end
    endcase
  end

  // State, FIFO bookkeeping and registered outputs. wr/data_oe are decoded
  // from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      txeMeta_q   <= 1'b1;
      txeSync_q   <= 1'b1;
      state_q     <= IDLE;
      cycCnt_q    <= '0;
      settle_q    <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= 1'b0;
      dataOe_q    <= 1'b0;
      dataOut_q   <= 8'h00;
      bytesSent_q <= 16'h0000;
    end else begin
      txeMeta_q <= port.txe;
      txeSync_q <= txeMeta_q;
      state_q   <= state_d;
      cycCnt_q  <= cycCnt_d;
      settle_q  <= (state_q == WAIT) && (state_d == IDLE);
      count_q   <= count_d;
      full_q    <= (count_d == CW'(DEPTH));
      wr_q      <= (state_d == STROBE);
      dataOe_q  <= (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      if (push) begin
        wrPtr_q <= wrPtr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rdPtr_q   <= rdPtr_q + DEPTH_LOG2'(1);
        dataOut_q <= mem[rdPtr_q];
      end
      if (port.newin && full_q) begin
        overflow_q <= 1'b1;
      end
      if (state_q == HOLD) begin
        bytesSent_q <= bytesSent_q + 16'd1;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtr_q] <= port.in;
    end
  end

  assign port.full       = full_q;
  assign port.count      = count_q;
  assign port.overflow   = overflow_q;
  assign port.data_out   = dataOut_q;
  assign port.data_oe    = dataOe_q;
  assign port.wr         = wr_q;
  assign port.bytes_sent = bytesSent_q;
  assign port.state      = state_q;

endmodule
